fetch_unit: RTL and testbench

Instruction fetch stage for the RV32I core. It sits directly upstream of the main decoder. It owns the PC, issues one word fetch at a time to instruction memory and holds the returned instruction until the core consumes it. `opcode` feeds the decoder's opcode input. Branch/jump redirects from execute cancel in-flight fetches cleanly.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for the RV32I core. Owns the PC, keeps at most one
//   word fetch outstanding to instruction memory and holds the returned word
//   until the core consumes it. Redirects from execute cancel in-flight
//   fetches: a response that is still owed at redirect time is waited out and
//   discarded before the new fetch is issued.
//
// Parameters
//   RESET_PC    first fetch address after reset (word aligned)
//   NOP_INSTR   value on instr while no valid instruction is held
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   imem_req     out  one-cycle fetch request pulse
//   imem_addr    out  fetch address, stable until the response
//   imem_rvalid  in   response pulse, imem_rdata valid this cycle
//   imem_rdata   in   instruction word
//   stall        in   core cannot accept the held instruction
//   redirect     in   taken branch / jal / jalr pulse
//   redirect_pc  in   redirect target, bits [1:0] ignored
//   instr        out  held instruction or NOP_INSTR
//   opcode       out  instr[6:0]
//   instr_pc     out  address of instr
//   instr_valid  out  instr is a real fetched instruction
// -----------------------------------------------------------------------------
//   state  | meaning
//   BOOT   | reset state, issues the first fetch at RESET_PC
//   WAIT   | one fetch outstanding, its response will be kept
//   HOLD   | instruction presented to the core
//   DROP   | stale fetch outstanding, refetch at pend_pc once it returns
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic [31:0] target_pc;
  logic [31:0] next_pc;
  logic        redirect_pc_unused;

  assign target_pc          = {redirect_pc[31:2], 2'b00};
  assign redirect_pc_unused = ^redirect_pc[1:0];
  // 32-bit add wraps naturally, so 0xFFFF_FFFC + 4 becomes 0
  assign next_pc            = instr_pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    imem_req_d    = 1'b0;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pend_pc_d     = pend_pc_q;

    case (state_q)
      S_BOOT: begin
        state_d     = S_WAIT;
        imem_req_d  = 1'b1;
        imem_addr_d = RESET_PC;
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            // response arrives together with the redirect: drop it and
            // refetch immediately, no response is owed any more
            imem_req_d  = 1'b1;
            imem_addr_d = target_pc;
          end else begin
            state_d       = S_HOLD;
            instr_d       = imem_rdata;
            instr_pc_d    = imem_addr_q;
            instr_valid_d = 1'b1;
          end
        end else if (redirect) begin
          state_d   = S_DROP;
          pend_pc_d = target_pc;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_d       = S_WAIT;
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          imem_addr_d   = target_pc;
        end else if (!stall) begin
          state_d       = S_WAIT;
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          imem_addr_d   = next_pc;
        end
      end

      S_DROP: begin
        if (imem_rvalid) begin
          state_d     = S_WAIT;
          imem_req_d  = 1'b1;
          imem_addr_d = redirect ? target_pc : pend_pc_q;
        end else if (redirect) begin
          pend_pc_d = target_pc;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      pend_pc_q     <= RESET_PC;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A behavioural instruction memory answers
//   each request after a programmable latency. Stimulus pushes the expected
//   fetch addresses and the expected delivered instructions into queues; two
//   monitors pop and compare whenever the DUT issues a request or presents a
//   new valid instruction.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] instr_pc;
  logic        instr_valid;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .opcode      (opcode),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'h13 ^ {2'b00, a[6:2]}};
  endfunction

  // ---------------- instruction memory model ----------------
  int          lat = 1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] maddr = 32'h0;
  logic        inj = 1'b0;

  assign imem_rvalid = mem_rvalid | inj;
  assign imem_rdata  = inj ? 32'hDEAD_BEEF : mem_rdata;

  always @(negedge clk) begin
    mem_rvalid <= 1'b0;
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      if (busy) begin
        if (cnt == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem_word(maddr);
          busy       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req) begin
        chk("req_while_owed", {31'b0, busy}, 32'd0);
        busy  <= 1'b1;
        cnt   <= lat;
        maddr <= imem_addr;
      end
    end
  end

  // ---------------- request monitor ----------------
  always @(negedge clk) begin
    if (rst_n && imem_req) begin
      if (exp_req.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
      end else begin
        chk("req_addr", imem_addr, exp_req.pop_front());
      end
    end
  end

  // ---------------- instruction monitor ----------------
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (exp_pc.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
      end else begin
        logic [31:0] e_pc, e_data;
        e_pc   = exp_pc.pop_front();
        e_data = exp_data.pop_front();
        chk("instr_pc", instr_pc, e_pc);
        chk("instr", instr, e_data);
        chk("opcode", {25'b0, opcode}, {25'b0, e_data[6:0]});
      end
    end
    if (!instr_valid) chk("nop_when_invalid", instr, NOP);
    prev_v <= instr_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [31:0] a);
    exp_pc.push_back(a);
    exp_data.push_back(mem_word(a));
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (instr_valid) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL timeout_%s: got no instr_valid expected one within 40 cycles", tag);
    end
  endtask

  task automatic wait_rvalid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (imem_rvalid) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL timeout_%s: got no imem_rvalid expected one within 40 cycles", tag);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_opcode"}, {25'b0, opcode}, 32'h13);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    step();
    step();
    check_reset("reset");

    // reset release, L = 1, sequential fetches 0x0, 0x4, 0x8
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    push_instr(32'h0);
    push_instr(32'h4);
    push_instr(32'h8);
    rst_n = 1'b1;
    wait_valid("i0");
    wait_valid("i4");
    step();
    stall = 1'b1;                       // raised in WAIT, takes effect in HOLD
    wait_valid("i8");

    // stall for 3 cycles while holding 0x8
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, mem_word(32'h8));
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    end
    exp_req.push_back(32'hC);
    push_instr(32'hC);
    stall = 1'b0;
    step();
    chk("req_after_stall", {31'b0, imem_req}, 32'd1);
    wait_valid("iC");

    // redirect in HOLD with stall asserted, misaligned target
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    exp_req.push_back(32'h100);
    push_instr(32'h100);
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("hold_redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("hold_redir_req", {31'b0, imem_req}, 32'd1);
    wait_valid("i100");

    // redirect during WAIT with L = 3, then a second redirect in DROP
    lat = 3;
    exp_req.push_back(32'h104);
    step();                             // 0x104 request now outstanding
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    exp_req.push_back(32'h80);
    wait_rvalid("stale");
    step();
    chk("req_after_stale", {31'b0, imem_req}, 32'd1);
    chk("drop_valid", {31'b0, instr_valid}, 32'd0);

    // redirect coinciding with the response in WAIT
    wait_rvalid("coinc");
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    exp_req.push_back(32'h200);
    push_instr(32'h200);
    step();
    redirect = 1'b0;
    chk("coinc_valid", {31'b0, instr_valid}, 32'd0);
    chk("coinc_req", {31'b0, imem_req}, 32'd1);
    wait_valid("i200");

    // jump to top of memory, consume, check wrap to 0
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    exp_req.push_back(32'hFFFF_FFFC);
    push_instr(32'hFFFF_FFFC);
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    wait_valid("itop");
    exp_req.push_back(32'h0);
    step();
    chk("wrap_req", {31'b0, imem_req}, 32'd1);

    // reset while WAIT with the 0x0 fetch outstanding
    rst_n = 1'b0;
    step();
    check_reset("mid_reset");
    step();

    // release with a late response landing in BOOT
    lat = 1;
    exp_req.push_back(32'h0);
    push_instr(32'h0);
    rst_n = 1'b1;
    inj   = 1'b1;
    step();
    inj = 1'b0;
    chk("boot_rvalid_valid", {31'b0, instr_valid}, 32'd0);
    chk("boot_rvalid_req", {31'b0, imem_req}, 32'd1);
    wait_valid("i0_again");

    stall = 1'b1;
    step();
    step();
    step();
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("instr_queue_empty", exp_pc.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got no finish expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
